// File: rtl/irq_pkg.sv
// Shared types and helpers for the external interrupt controller.
package irq_pkg;

   // Request/acknowledge/service handshake states.
   typedef enum logic [1:0] {
      IRQ_IDLE    = 2'd0,
      IRQ_REQ     = 2'd1,
      IRQ_SERVICE = 2'd2
   } irq_state_t;

   localparam int unsigned IRQ_MAX_SRC = 16;

   // Width of a source id; never narrower than one bit.
   function automatic int unsigned irq_id_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports whether any bit is set and the lowest set index.
module irq_prio_enc
   import irq_pkg::*;
#(
   parameter int unsigned N_SRC = 4
) (
   input  logic [N_SRC-1:0]           i_vec,
   output logic                       o_valid,
   output logic [irq_id_w(N_SRC)-1:0] o_idx
);

   localparam int unsigned IdW = irq_id_w(N_SRC);

   // Scan from the top down so the lowest set index is the last one written.
   always_comb begin
      o_valid = |i_vec;
      o_idx   = '0;
      for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
         if (i_vec[i]) begin
            o_idx = IdW'(i);
         end
      end
   end

endmodule

// File: rtl/ext_irq_controller.sv
// External interrupt controller: synchronizes and edge-detects the source lines, keeps sticky
// pending bits, picks the highest-priority unmasked source and runs the ExtIRQ/ExtIAck/ERET
// handshake with the core. Only one source is in service at a time; no nesting.
module ext_irq_controller
   import irq_pkg::*;
#(
   parameter int unsigned N_SRC   = 4,
   parameter bit          SYNC_EN = 1'b1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_SRC-1:0]           irq_src,
   input  logic                       cfg_we,
   input  logic [N_SRC-1:0]           cfg_mask,
   input  logic                       ExtIAck,
   input  logic                       ERet,
   output logic                       ExtIRQ,
   output logic [irq_id_w(N_SRC)-1:0] irq_id,
   output logic                       irq_busy,
   output logic [N_SRC-1:0]           src_ack,
   output logic [N_SRC-1:0]           mask_q
);

   localparam int unsigned IdW = irq_id_w(N_SRC);

   logic [N_SRC-1:0] w_src;
   logic [N_SRC-1:0] r_src_prev;
   logic [N_SRC-1:0] w_rise;
   logic [N_SRC-1:0] r_pend;
   logic [N_SRC-1:0] r_mask;
   logic [N_SRC-1:0] w_elig;
   logic [N_SRC-1:0] w_id_onehot;
   logic [N_SRC-1:0] w_clr;
   logic             w_sel_valid;
   logic [IdW-1:0]   w_sel_idx;
   logic             w_id_enabled;
   logic             w_ack_fire;

   irq_state_t       r_state;
   irq_state_t       w_state_d;
   logic [IdW-1:0]   r_id;
   logic [IdW-1:0]   w_id_d;

   // ---------------------------------------------------------------------------------------------
   // Input conditioning
   // ---------------------------------------------------------------------------------------------
   if (SYNC_EN) begin : g_sync
      logic [N_SRC-1:0] r_sync1;
      logic [N_SRC-1:0] r_sync2;

      // Two-flop synchronizer for asynchronous board lines.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
         end else begin
            r_sync1 <= irq_src;
            r_sync2 <= r_sync1;
         end
      end

      assign w_src = r_sync2;
   end else begin : g_nosync
      assign w_src = irq_src;
   end

   // Edge history for rising-edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_src_prev <= '0;
      end else begin
         r_src_prev <= w_src;
      end
   end

   assign w_rise = w_src & ~r_src_prev;

   // ---------------------------------------------------------------------------------------------
   // Pending and mask registers
   // ---------------------------------------------------------------------------------------------
   // Sticky pending bits; a fresh edge overrides the acknowledge clear in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pend <= '0;
      end else begin
         r_pend <= (r_pend & ~w_clr) | w_rise;
      end
   end

   // Mask register; a write takes effect from the following cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mask <= '0;
      end else if (cfg_we) begin
         r_mask <= cfg_mask;
      end
   end

   assign w_elig = r_pend & r_mask;

   irq_prio_enc #(
      .N_SRC (N_SRC)
   ) u_prio_enc (
      .i_vec   (w_elig),
      .o_valid (w_sel_valid),
      .o_idx   (w_sel_idx)
   );

   // Decode the latched id to one-hot for ack pulse, pending clear and mask lookup.
   always_comb begin
      w_id_onehot = '0;
      for (int i = 0; i < int'(N_SRC); i++) begin
         w_id_onehot[i] = (r_id == IdW'(i));
      end
   end

   assign w_id_enabled = |(w_id_onehot & r_mask);

   // ---------------------------------------------------------------------------------------------
   // Handshake FSM
   // ---------------------------------------------------------------------------------------------
   // State and latched id registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IRQ_IDLE;
         r_id    <= '0;
      end else begin
         r_state <= w_state_d;
         r_id    <= w_id_d;
      end
   end

   // Next-state logic; the id is only sampled in IDLE, so later arrivals never preempt.
   always_comb begin
      w_state_d  = r_state;
      w_id_d     = r_id;
      w_ack_fire = 1'b0;
      unique case (r_state)
         IRQ_IDLE: begin
            if (w_sel_valid) begin
               w_state_d = IRQ_REQ;
               w_id_d    = w_sel_idx;
            end
         end
         IRQ_REQ: begin
            // Acknowledge wins over a same-cycle mask write, which only lands next cycle.
            if (ExtIAck) begin
               w_ack_fire = 1'b1;
               w_state_d  = IRQ_SERVICE;
            end else if (!w_id_enabled) begin
               w_state_d = IRQ_IDLE;
            end
         end
         IRQ_SERVICE: begin
            if (ERet) begin
               w_state_d = IRQ_IDLE;
            end
         end
         default: begin
            w_state_d = IRQ_IDLE;
         end
      endcase
   end

   assign w_clr = w_ack_fire ? w_id_onehot : '0;

   // ---------------------------------------------------------------------------------------------
   // Outputs: request, busy and id come from registered state only.
   // ---------------------------------------------------------------------------------------------
   assign ExtIRQ   = (r_state == IRQ_REQ);
   assign irq_busy = (r_state == IRQ_SERVICE);
   assign irq_id   = r_id;
   assign src_ack  = w_clr;
   assign mask_q   = r_mask;

endmodule

// File: tb/tb_ext_irq_controller.sv
// Self-checking bench for ext_irq_controller (N_SRC=4, SYNC_EN=1).
module tb_ext_irq_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] irq_src;
   logic       cfg_we;
   logic [3:0] cfg_mask;
   logic       ExtIAck;
   logic       ERet;
   logic       ExtIRQ;
   logic [1:0] irq_id;
   logic       irq_busy;
   logic [3:0] src_ack;
   logic [3:0] mask_q;

   int          n_tests = 0;
   int          n_fail  = 0;
   int unsigned exp_q[$];

   typedef struct {
      logic [3:0]  src;
      logic [3:0]  mask;
      bit          valid;
      int unsigned id;
   } vec_t;

   vec_t vecs[8];

   ext_irq_controller #(
      .N_SRC   (4),
      .SYNC_EN (1'b1)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .irq_src  (irq_src),
      .cfg_we   (cfg_we),
      .cfg_mask (cfg_mask),
      .ExtIAck  (ExtIAck),
      .ERet     (ERet),
      .ExtIRQ   (ExtIRQ),
      .irq_id   (irq_id),
      .irq_busy (irq_busy),
      .src_ack  (src_ack),
      .mask_q   (mask_q)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b0;
      irq_src  = '0;
      cfg_we   = 1'b0;
      cfg_mask = '0;
      ExtIAck  = 1'b0;
      ERet     = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      step();
   endtask

   task automatic write_mask(input logic [3:0] m);
      step();
      cfg_we   = 1'b1;
      cfg_mask = m;
      step();
      cfg_we   = 1'b0;
   endtask

   task automatic pulse(input logic [3:0] v);
      step();
      irq_src = irq_src | v;
      step();
      step();
      irq_src = irq_src & ~v;
   endtask

   // Wait for a request and compare its id with the scoreboard head.
   task automatic wait_req(input string name, input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (ExtIRQ) seen = 1'b1;
      end
      check($sformatf("%s_irq", name), 32'(ExtIRQ), 32'd1);
      if (exp_q.size() > 0) check($sformatf("%s_id", name), 32'(irq_id), exp_q.pop_front());
      else check($sformatf("%s_sb_empty", name), 32'(exp_q.size()), 32'd1);
   endtask

   task automatic no_req(input string name, input int cycles);
      bit seen = 1'b0;
      repeat (cycles) begin
         @(negedge clk);
         if (ExtIRQ) seen = 1'b1;
      end
      check(name, 32'(seen), 32'd0);
   endtask

   task automatic do_ack(input string name, input logic [3:0] oh);
      step();
      ExtIAck = 1'b1;
      @(negedge clk);
      check($sformatf("%s_src_ack", name), 32'(src_ack), 32'(oh));
      step();
      ExtIAck = 1'b0;
      @(negedge clk);
      check($sformatf("%s_busy", name), 32'(irq_busy), 32'd1);
      check($sformatf("%s_irq_low", name), 32'(ExtIRQ), 32'd0);
      check($sformatf("%s_ack_pulse", name), 32'(src_ack), 32'd0);
   endtask

   task automatic do_eret(input string name);
      step();
      ERet = 1'b1;
      step();
      ERet = 1'b0;
      @(negedge clk);
      check($sformatf("%s_eret_busy", name), 32'(irq_busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{src: 4'b0100, mask: 4'b1111, valid: 1'b1, id: 2};
      vecs[1] = '{src: 4'b1001, mask: 4'b1111, valid: 1'b1, id: 0};
      vecs[2] = '{src: 4'b1010, mask: 4'b1111, valid: 1'b1, id: 1};
      vecs[3] = '{src: 4'b1000, mask: 4'b1111, valid: 1'b1, id: 3};
      vecs[4] = '{src: 4'b0001, mask: 4'b1110, valid: 1'b0, id: 0};
      vecs[5] = '{src: 4'b0110, mask: 4'b1011, valid: 1'b1, id: 1};
      vecs[6] = '{src: 4'b1100, mask: 4'b0111, valid: 1'b1, id: 2};
      vecs[7] = '{src: 4'b1111, mask: 4'b1000, valid: 1'b1, id: 3};

      // Reset values
      do_reset();
      check("reset_irq", 32'(ExtIRQ), 32'd0);
      check("reset_busy", 32'(irq_busy), 32'd0);
      check("reset_mask", 32'(mask_q), 32'd0);

      // Table-driven priority/mask vectors, each from a clean reset
      foreach (vecs[k]) begin
         logic [3:0] oh;
         string      nm;
         nm = $sformatf("vec%0d", k);
         oh = 4'b0001 << vecs[k].id;
         do_reset();
         write_mask(vecs[k].mask);
         check($sformatf("%s_mask_q", nm), 32'(mask_q), 32'(vecs[k].mask));
         if (vecs[k].valid) exp_q.push_back(vecs[k].id);
         pulse(vecs[k].src);
         if (vecs[k].valid) begin
            wait_req(nm, 12);
            do_ack(nm, oh);
            do_eret(nm);
         end else begin
            no_req(nm, 12);
         end
      end

      // 1: reset during REQ with two pending sources
      do_reset();
      write_mask(4'hF);
      exp_q.push_back(1);
      pulse(4'b0110);
      wait_req("t1_pre", 12);
      #2 reset = 1'b0;
      #1;
      check("t1_irq", 32'(ExtIRQ), 32'd0);
      check("t1_busy", 32'(irq_busy), 32'd0);
      check("t1_id", 32'(irq_id), 32'd0);
      check("t1_src_ack", 32'(src_ack), 32'd0);
      check("t1_mask", 32'(mask_q), 32'd0);
      step();
      reset = 1'b1;
      write_mask(4'hF);
      no_req("t1_pend_cleared", 10);

      // 2: single interrupt full handshake
      do_reset();
      write_mask(4'hF);
      exp_q.push_back(2);
      pulse(4'b0100);
      wait_req("t2", 12);
      do_ack("t2", 4'b0100);
      do_eret("t2");
      no_req("t2_idle", 6);

      // 3: no preemption, then lower-priority-first order resolves
      do_reset();
      write_mask(4'hF);
      exp_q.push_back(3);
      pulse(4'b1000);
      wait_req("t3a", 12);
      pulse(4'b0001);
      repeat (4) @(negedge clk);
      check("t3_hold_id", 32'(irq_id), 32'd3);
      check("t3_hold_irq", 32'(ExtIRQ), 32'd1);
      do_ack("t3a", 4'b1000);
      do_eret("t3a");
      exp_q.push_back(0);
      wait_req("t3b", 8);
      do_ack("t3b", 4'b0001);
      do_eret("t3b");
      no_req("t3_done", 10);

      // 4: masking holds off, unmask releases; masking in REQ drops the request
      do_reset();
      write_mask(4'b1110);
      pulse(4'b0001);
      no_req("t4_masked", 10);
      exp_q.push_back(0);
      write_mask(4'hF);
      wait_req("t4_unmask", 8);
      do_ack("t4a", 4'b0001);
      do_eret("t4a");
      exp_q.push_back(1);
      pulse(4'b0010);
      wait_req("t4b", 12);
      write_mask(4'b1101);
      step();
      no_req("t4_drop", 5);
      exp_q.push_back(1);
      write_mask(4'hF);
      wait_req("t4_repend", 8);
      do_ack("t4c", 4'b0010);
      do_eret("t4c");

      // 5: a new edge in the acknowledge cycle keeps the source pending
      do_reset();
      write_mask(4'hF);
      exp_q.push_back(1);
      pulse(4'b0010);
      wait_req("t5a", 12);
      step();
      irq_src[1] = 1'b1;
      step();
      step();
      ExtIAck = 1'b1;
      @(negedge clk);
      check("t5_src_ack", 32'(src_ack), 32'b0010);
      step();
      ExtIAck    = 1'b0;
      irq_src[1] = 1'b0;
      do_eret("t5a");
      exp_q.push_back(1);
      wait_req("t5_again", 8);
      do_ack("t5b", 4'b0010);
      do_eret("t5b");

      // 6: spurious ERET in IDLE and ExtIAck in SERVICE are ignored
      do_reset();
      write_mask(4'hF);
      step();
      ERet = 1'b1;
      step();
      ERet = 1'b0;
      no_req("t6_eret_idle", 5);
      check("t6_idle_busy", 32'(irq_busy), 32'd0);
      exp_q.push_back(2);
      pulse(4'b0100);
      wait_req("t6", 12);
      do_ack("t6", 4'b0100);
      step();
      ExtIAck = 1'b1;
      @(negedge clk);
      check("t6_spurious_ack", 32'(src_ack), 32'd0);
      step();
      ExtIAck = 1'b0;
      @(negedge clk);
      check("t6_still_busy", 32'(irq_busy), 32'd1);
      do_eret("t6");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
